// File: rtl/compress_pkg.sv
// Shared types and default sizing for the token-table compressor.
// codeword_t and the DEF_* constants describe the default 32-bit configuration.
package compress_pkg;

    localparam int CW_WIDTH       = 32;
    localparam int DEF_TOKEN_BITS = 4;
    localparam int DEF_CNT_W      = 16;
    localparam int DEPTH          = 2 ** DEF_TOKEN_BITS;
    localparam logic [DEF_CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic                token;
        logic [CW_WIDTH-1:0] data;
    } codeword_t;

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

endpackage

// File: rtl/token_cam.sv
// Programmable dictionary: entry storage, valid bits, load/clear and a
// combinational parallel match that reports the lowest matching index.
module token_cam #(
    parameter int WIDTH      = 32,
    parameter int TOKEN_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_en,
    input  logic [TOKEN_BITS-1:0] load_idx,
    input  logic [WIDTH-1:0]      load_data,
    input  logic                  table_clr,
    input  logic [WIDTH-1:0]      lookup_data,
    output logic                  hit,
    output logic [TOKEN_BITS-1:0] hit_idx
);

    localparam int ENTRIES = 2 ** TOKEN_BITS;

    logic [WIDTH-1:0]   entries [ENTRIES];
    logic [ENTRIES-1:0] valid;

    always_ff @(posedge clk) begin
        if (load_en) begin
            entries[load_idx] <= load_data;
        end
    end

    // The later load assignment overrides the clear for that one bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= '0;
        end else begin
            if (table_clr) begin
                valid <= '0;
            end
            if (load_en) begin
                valid[load_idx] <= 1'b1;
            end
        end
    end

    // Scan from the top down so the lowest matching index is the last one written.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && (entries[i] == lookup_data)) begin
                hit     = 1'b1;
                hit_idx = TOKEN_BITS'(i);
            end
        end
    end

endmodule

// File: rtl/token_compressor.sv
// Encode side of the token-table path: valid/ready handshake, a single-stage
// codeword register driven by a dictionary lookup, and saturating hit/miss counters.
module token_compressor
    import compress_pkg::*;
#(
    parameter int WIDTH      = CW_WIDTH,
    parameter int TOKEN_BITS = DEF_TOKEN_BITS,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_token,
    output logic [WIDTH-1:0]      out_data,
    input  logic                  load_en,
    input  logic [TOKEN_BITS-1:0] load_idx,
    input  logic [WIDTH-1:0]      load_data,
    input  logic                  table_clr,
    output logic [CNT_W-1:0]      hit_count,
    output logic [CNT_W-1:0]      miss_count
);

    state_t                state;
    state_t                state_next;
    logic                  hit;
    logic [TOKEN_BITS-1:0] hit_idx;
    logic                  accept;
    logic                  drain;

    // Table writes block input so a lookup never races a dictionary update.
    assign in_ready  = !load_en && !table_clr && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign out_valid = (state == FULL);

    token_cam #(
        .WIDTH      (WIDTH),
        .TOKEN_BITS (TOKEN_BITS)
    ) u_cam (
        .clk         (clk),
        .reset       (reset),
        .load_en     (load_en),
        .load_idx    (load_idx),
        .load_data   (load_data),
        .table_clr   (table_clr),
        .lookup_data (in_data),
        .hit         (hit),
        .hit_idx     (hit_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (accept) state_next = FULL;
            FULL:    if (drain && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_token <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_token <= hit;
            out_data  <= hit ? WIDTH'(hit_idx) : in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (drain) begin
            if (out_token && (hit_count != '1)) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            if (!out_token && (miss_count != '1)) begin
                miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

endmodule
